clock_set_ctrl: RTL and testbench



---
 rtl/clock_set_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//
// Front-panel controller for setting the VGA clock's time counters with two
// buttons, MODE and INC. Both buttons are synchronised every clk and debounced
// on the frame cadence. A mode FSM walks RUN -> SET_HRS -> SET_MIN -> SET_SEC
// -> RUN on each debounced MODE press, returns to RUN after a period of
// inactivity, drives the counters' level-sensitive adjust inputs while INC is
// held, and produces per-field blank flags so the field being set blinks.
//
// Ports:
//   clk         in   pixel/core clock
//   reset       in   synchronous, active-high
//   frame_end   in   one-cycle pulse per frame; all state updates happen here
//   btn_mode    in   raw asynchronous MODE button, active-high
//   btn_inc     in   raw asynchronous INC button, active-high
//   adj_hrs     out  high while INC is held in SET_HRS
//   adj_min     out  high while INC is held in SET_MIN
//   adj_sec     out  high while INC is held in SET_SEC
//   blank_hrs   out  blank mask for the hours digits
//   blank_min   out  blank mask for the minutes digits
//   blank_sec   out  blank mask for the seconds digits
//   setting     out  high in any SET state
//   mode_state  out  0=RUN, 1=SET_HRS, 2=SET_MIN, 3=SET_SEC
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int BLINK_FRAMES    = 16,
    parameter int TIMEOUT_FRAMES  = 600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_end,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       adj_hrs,
    output logic       adj_min,
    output logic       adj_sec,
    output logic       blank_hrs,
    output logic       blank_min,
    output logic       blank_sec,
    output logic       setting,
    output logic [1:0] mode_state
);

    localparam int DB_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int BL_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int TO_W = $clog2(TIMEOUT_FRAMES + 1);

    localparam logic [DB_W-1:0] DB_LIM  = DB_W'(DEBOUNCE_FRAMES);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_FRAMES - 1);
    localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT_FRAMES);

    typedef enum logic [1:0] {
        ST_RUN = 2'd0,
        ST_HRS = 2'd1,
        ST_MIN = 2'd2,
        ST_SEC = 2'd3
    } state_t;

    // Synchroniser chains
    logic mode_s1_q, mode_s2_q;
    logic inc_s1_q, inc_s2_q;

    // Debounce state
    logic            mode_deb_q, mode_deb_d;
    logic [DB_W-1:0] mode_cnt_q, mode_cnt_d;
    logic            inc_deb_q, inc_deb_d;
    logic [DB_W-1:0] inc_cnt_q, inc_cnt_d;

    // Set once MODE has been seen released after reset, so a button held
    // through reset does not register as a press when it debounces high.
    logic            mode_arm_q, mode_arm_d;

    state_t          state_q, state_d;
    logic [TO_W-1:0] tmo_q, tmo_d;
    logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_ph_q, blink_ph_d;

    logic            adj_hrs_q, adj_hrs_d;
    logic            adj_min_q, adj_min_d;
    logic            adj_sec_q, adj_sec_d;
    logic            blank_hrs_q, blank_hrs_d;
    logic            blank_min_q, blank_min_d;
    logic            blank_sec_q, blank_sec_d;
    logic            setting_q, setting_d;

    logic            mode_press;

    // One frame of debounce: returns {debounced level, stability count}.
    function automatic logic [DB_W:0] db_step(input logic            sync,
                                              input logic            deb,
                                              input logic [DB_W-1:0] cnt);
        logic [DB_W-1:0] nxt;
        if (sync == deb) begin
            return {deb, {DB_W{1'b0}}};
        end
        nxt = cnt + DB_W'(1);
        if (nxt == DB_LIM) begin
            return {sync, {DB_W{1'b0}}};
        end
        return {deb, nxt};
    endfunction

    function automatic state_t next_mode(input state_t s);
        case (s)
            ST_RUN:  return ST_HRS;
            ST_HRS:  return ST_MIN;
            ST_MIN:  return ST_SEC;
            default: return ST_RUN;
        endcase
    endfunction

    always_comb begin
        mode_deb_d  = mode_deb_q;
        mode_cnt_d  = mode_cnt_q;
        inc_deb_d   = inc_deb_q;
        inc_cnt_d   = inc_cnt_q;
        mode_arm_d  = mode_arm_q;
        state_d     = state_q;
        tmo_d       = tmo_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        adj_hrs_d   = adj_hrs_q;
        adj_min_d   = adj_min_q;
        adj_sec_d   = adj_sec_q;
        blank_hrs_d = blank_hrs_q;
        blank_min_d = blank_min_q;
        blank_sec_d = blank_sec_q;
        setting_d   = setting_q;
        mode_press  = 1'b0;

        if (frame_end) begin
            {mode_deb_d, mode_cnt_d} = db_step(mode_s2_q, mode_deb_q, mode_cnt_q);
            {inc_deb_d, inc_cnt_d}   = db_step(inc_s2_q, inc_deb_q, inc_cnt_q);

            mode_arm_d = mode_arm_q | ~mode_s2_q;
            mode_press = mode_arm_q & ~mode_deb_q & mode_deb_d;

            if (state_q == ST_RUN || mode_press || inc_deb_d) begin
                tmo_d = '0;
            end else if (tmo_q != TO_LIM) begin
                tmo_d = tmo_q + TO_W'(1);
            end

            // A press wins over a timeout landing on the same frame.
            if (mode_press) begin
                state_d = next_mode(state_q);
            end else if (state_q != ST_RUN && tmo_d == TO_LIM) begin
                state_d = ST_RUN;
            end

            // Restart the blink on every state change so the new field
            // starts visible.
            if (state_d != state_q) begin
                blink_cnt_d = '0;
                blink_ph_d  = 1'b0;
            end else if (blink_cnt_q == BL_LAST) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BL_W'(1);
            end

            // Adjust strobes are held off on the frame the mode changes.
            adj_hrs_d = ~mode_press & inc_deb_d & (state_d == ST_HRS);
            adj_min_d = ~mode_press & inc_deb_d & (state_d == ST_MIN);
            adj_sec_d = ~mode_press & inc_deb_d & (state_d == ST_SEC);

            // Field stays solid while it is being incremented.
            blank_hrs_d = (state_d == ST_HRS) & blink_ph_d & ~inc_deb_d;
            blank_min_d = (state_d == ST_MIN) & blink_ph_d & ~inc_deb_d;
            blank_sec_d = (state_d == ST_SEC) & blink_ph_d & ~inc_deb_d;

            setting_d = (state_d != ST_RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_s1_q   <= 1'b0;
            mode_s2_q   <= 1'b0;
            inc_s1_q    <= 1'b0;
            inc_s2_q    <= 1'b0;
            mode_deb_q  <= 1'b0;
            mode_cnt_q  <= '0;
            inc_deb_q   <= 1'b0;
            inc_cnt_q   <= '0;
            mode_arm_q  <= 1'b0;
            state_q     <= ST_RUN;
            tmo_q       <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            adj_hrs_q   <= 1'b0;
            adj_min_q   <= 1'b0;
            adj_sec_q   <= 1'b0;
            blank_hrs_q <= 1'b0;
            blank_min_q <= 1'b0;
            blank_sec_q <= 1'b0;
            setting_q   <= 1'b0;
        end else begin
            mode_s1_q   <= btn_mode;
            mode_s2_q   <= mode_s1_q;
            inc_s1_q    <= btn_inc;
            inc_s2_q    <= inc_s1_q;
            mode_deb_q  <= mode_deb_d;
            mode_cnt_q  <= mode_cnt_d;
            inc_deb_q   <= inc_deb_d;
            inc_cnt_q   <= inc_cnt_d;
            mode_arm_q  <= mode_arm_d;
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            adj_hrs_q   <= adj_hrs_d;
            adj_min_q   <= adj_min_d;
            adj_sec_q   <= adj_sec_d;
            blank_hrs_q <= blank_hrs_d;
            blank_min_q <= blank_min_d;
            blank_sec_q <= blank_sec_d;
            setting_q   <= setting_d;
        end
    end

    assign adj_hrs    = adj_hrs_q;
    assign adj_min    = adj_min_q;
    assign adj_sec    = adj_sec_q;
    assign blank_hrs  = blank_hrs_q;
    assign blank_min  = blank_min_q;
    assign blank_sec  = blank_sec_q;
    assign setting    = setting_q;
    assign mode_state = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for clock_set_ctrl (DEBOUNCE_FRAMES=2, BLINK_FRAMES=4,
// TIMEOUT_FRAMES=8, frame_end every 10 clk). Each scenario is a per-frame
// table of button levels and expected outputs; expected vectors are queued
// before a frame is driven and popped once the frame_end edge has passed.
// Output vector layout: {mode_state[1:0], setting, adj_hrs, adj_min, adj_sec,
// blank_hrs, blank_min, blank_sec}.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_end = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       adj_hrs, adj_min, adj_sec;
    logic       blank_hrs, blank_min, blank_sec;
    logic       setting;
    logic [1:0] mode_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] pre_vec;

    clock_set_ctrl #(
        .DEBOUNCE_FRAMES(2),
        .BLINK_FRAMES   (4),
        .TIMEOUT_FRAMES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .frame_end (frame_end),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .adj_hrs   (adj_hrs),
        .adj_min   (adj_min),
        .adj_sec   (adj_sec),
        .blank_hrs (blank_hrs),
        .blank_min (blank_min),
        .blank_sec (blank_sec),
        .setting   (setting),
        .mode_state(mode_state)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] obs();
        return {mode_state, setting, adj_hrs, adj_min, adj_sec,
                blank_hrs, blank_min, blank_sec};
    endfunction

    // Field letter: 'h','m','s' select one field, anything else none.
    function automatic logic [2:0] fld(input byte c);
        case (c)
            "h":     return 3'b100;
            "m":     return 3'b010;
            "s":     return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [8:0] ev(input byte st_c, input byte ad_c, input byte bl_c);
        int st;
        st = int'(st_c) - 48;
        return {st[1:0], (st != 0), fld(ad_c), fld(bl_c)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: set buttons, wait 9 cycles, pulse frame_end for one cycle.
    // pre_vec captures the outputs during the frame_end cycle, before its edge.
    task automatic drive_frame(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        repeat (9) tick();
        frame_end = 1'b1;
        pre_vec = obs();
        tick();
        frame_end = 1'b0;
    endtask

    task automatic do_reset();
        btn_mode  = 1'b0;
        btn_inc   = 1'b0;
        frame_end = 1'b0;
        reset     = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        drive_frame(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        string m_s, i_s, st_s, ad_s, bl_s;
        logic [8:0] got, want;
        btn_mode  = 1'b1;
        btn_inc   = 1'b1;
        frame_end = 1'b0;
        reset     = 1'b1;
        repeat (3) tick();
        got = obs();
        n_checks++;
        if (got !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b", got, 9'b0);
        end
        reset = 1'b0;
        // MODE held through reset must not count as a press until released.
        m_s  = "11001100";
        i_s  = "11000011";
        st_s = "00000111";
        ad_s = "-------h";
        bl_s = "--------";
        for (int f = 0; f < 8; f++) begin
            exp_q.push_back(ev(st_s[f], ad_s[f], bl_s[f]));
            drive_frame(m_s[f] == "1", i_s[f] == "1");
            got  = obs();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_release f%0d: got %b want %b", f, got, want);
            end
        end
        // Reset in SET_HRS with INC held clears adj on the same edge.
        reset = 1'b1;
        tick();
        got = obs();
        n_checks++;
        if (got !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_mid_set: got %b want %b", got, 9'b0);
        end
        reset = 1'b0;
    endtask

    task automatic test_mode_walk();
        string m_s, st_s;
        logic [8:0] got, want, prev;
        do_reset();
        m_s  = "10011001100110011";
        st_s = "00001111222233330";
        prev = obs();
        for (int f = 0; f < 17; f++) begin
            exp_q.push_back(ev(st_s[f], "-", "-"));
            drive_frame(m_s[f] == "1", 1'b0);
            n_checks++;
            if (pre_vec !== prev) begin
                n_fail++;
                $display("FAIL walk_hold f%0d: got %b want %b", f, pre_vec, prev);
            end
            got  = obs();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL walk f%0d: got %b want %b", f, got, want);
            end
            prev = got;
        end
    endtask

    task automatic test_increment();
        string m_s, i_s, st_s, ad_s;
        logic [8:0] got, want;
        do_reset();
        m_s  = "11001100000000";
        i_s  = "00000011111100";
        st_s = "01111222222222";
        ad_s = "-------mmmmmm-";
        for (int f = 0; f < 14; f++) begin
            exp_q.push_back(ev(st_s[f], ad_s[f], "-"));
            drive_frame(m_s[f] == "1", i_s[f] == "1");
            got  = obs();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL increment f%0d: got %b want %b", f, got, want);
            end
        end
    endtask

    task automatic test_blink();
        string m_s, st_s, bl_s;
        logic [8:0] got, want, prev;
        do_reset();
        m_s  = "110011001100000000";
        st_s = "011112222333333330";
        bl_s = "-------------ssss-";
        prev = obs();
        for (int f = 0; f < 18; f++) begin
            exp_q.push_back(ev(st_s[f], "-", bl_s[f]));
            drive_frame(m_s[f] == "1", 1'b0);
            n_checks++;
            if (pre_vec !== prev) begin
                n_fail++;
                $display("FAIL blink_hold f%0d: got %b want %b", f, pre_vec, prev);
            end
            got  = obs();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL blink f%0d: got %b want %b", f, got, want);
            end
            prev = got;
        end
    endtask

    task automatic test_timeout();
        string m_s, st_s, bl_s;
        logic [8:0] got, want;
        do_reset();
        m_s  = "1100000000";
        st_s = "0111111110";
        bl_s = "-----hhhh-";
        for (int f = 0; f < 10; f++) begin
            exp_q.push_back(ev(st_s[f], "-", bl_s[f]));
            drive_frame(m_s[f] == "1", 1'b0);
            got  = obs();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL timeout f%0d: got %b want %b", f, got, want);
            end
        end
    endtask

    task automatic test_both_buttons();
        string m_s, i_s, st_s, ad_s;
        logic [8:0] got, want;
        do_reset();
        m_s  = "11001100";
        i_s  = "00001110";
        st_s = "01111222";
        ad_s = "------mm";
        for (int f = 0; f < 8; f++) begin
            exp_q.push_back(ev(st_s[f], ad_s[f], "-"));
            drive_frame(m_s[f] == "1", i_s[f] == "1");
            got  = obs();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL both_buttons f%0d: got %b want %b", f, got, want);
            end
        end
    endtask

    task automatic test_press_at_timeout();
        string m_s, st_s, bl_s;
        logic [8:0] got, want;
        do_reset();
        m_s  = "11000000110";
        st_s = "01111111122";
        bl_s = "-----hhhh--";
        for (int f = 0; f < 11; f++) begin
            exp_q.push_back(ev(st_s[f], "-", bl_s[f]));
            drive_frame(m_s[f] == "1", 1'b0);
            got  = obs();
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL press_at_timeout f%0d: got %b want %b", f, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode_walk();
        test_increment();
        test_blink();
        test_timeout();
        test_both_buttons();
        test_press_at_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
